// File: rtl/settle_sampler_ctrl.sv
`timescale 1ns/1ps
// settle_sampler_ctrl
// Launches one registered operand pair into a slow combinational datapath,
// waits a fixed number of clock edges for it to settle, then captures the
// result and holds it for a valid/ready consumer. dp_c is only ever sampled
// at the final settle edge, so glitches never reach out_c.
// Optional build macro: SETTLE_SAMPLER_CHECK_IDEAL_EN enables a comparison of
// the captured sample against the zero-delay datapath function.
//
// state  | meaning
// IDLE   | ready for an operand pair, dp_a/dp_b hold the last operands
// WAIT   | operands launched, counting down the settle window
// DONE   | result captured, waiting for the consumer handshake
module settle_sampler_ctrl #(
    parameter int WIDTH         = 1,
    parameter int SETTLE_CYCLES = 6,
    parameter int CNT_W         = 4,
    parameter int TXN_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    input  logic [WIDTH-1:0] dp_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic             busy,
    output logic [TXN_W-1:0] txn_cnt,
    output logic             mismatch,
    output logic             err_sticky
);

    // A zero-length window still needs one edge between launch and capture.
    localparam int              LOAD_N = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD_N);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dp_a_q, dp_a_d;
    logic [WIDTH-1:0] dp_b_q, dp_b_d;
    logic [WIDTH-1:0] out_c_q, out_c_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TXN_W-1:0] txn_q, txn_d;

    // Next-state and datapath register updates for the sequencer
    always_comb begin
        state_d     = state_q;
        dp_a_d      = dp_a_q;
        dp_b_d      = dp_b_q;
        out_c_d     = out_c_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        txn_d       = txn_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dp_a_d  = in_a;
                    dp_b_d  = in_b;
                    cnt_d   = LOAD_V;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    out_c_d     = dp_c;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    txn_d       = txn_q + TXN_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            out_c_q     <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            txn_q       <= '0;
        end else begin
            state_q     <= state_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            out_c_q     <= out_c_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            txn_q       <= txn_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign out_c     = out_c_q;
    assign out_valid = out_valid_q;
    assign txn_cnt   = txn_q;

`ifdef SETTLE_SAMPLER_CHECK_IDEAL_EN
    logic mismatch_q, err_sticky_q;
    logic capture, ideal_miss;

    assign capture    = (state_q == S_WAIT) && (cnt_q == CNT_ONE);
    assign ideal_miss = (dp_c != ((dp_a_q & dp_b_q) | dp_b_q));

    // Flag a capture that disagrees with the zero-delay function of dp_a/dp_b
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else if (capture) begin
            mismatch_q <= ideal_miss;
            if (ideal_miss) begin
                err_sticky_q <= 1'b1;
            end
        end else if ((state_q == S_DONE) && out_ready) begin
            mismatch_q <= 1'b0;
        end
    end

    assign mismatch   = mismatch_q;
    assign err_sticky = err_sticky_q;
`else
    assign mismatch   = 1'b0;
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_settle_sampler_ctrl.sv
`timescale 1ns/1ps
// Bench for settle_sampler_ctrl: three instances (settle 6, settle 0, and
// settle 1 on a fast clock) each driving a gate-delay OR->AND datapath model.
module tb_settle_sampler_ctrl;

    localparam int W     = 1;
    localparam int TXN_W = 8;
    localparam int SET_A = 6;

`ifdef SETTLE_SAMPLER_CHECK_IDEAL_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic clk_f = 1'b0;
    always #5 clk   = ~clk;
    always #1 clk_f = ~clk_f;

    int checks = 0;
    int errors = 0;

    // instance A: SETTLE_CYCLES=6, clk
    logic a_rst = 1'b1, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [W-1:0] a_in_a = '0, a_in_b = '0;
    logic a_in_ready, a_out_valid, a_busy, a_mis, a_err;
    logic [W-1:0] a_dp_a, a_dp_b, a_dp_c, a_out_c, a_or;
    logic [TXN_W-1:0] a_txn;

    // instance B: SETTLE_CYCLES=0, clk
    logic b_rst = 1'b1, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [W-1:0] b_in_a = '0, b_in_b = '0;
    logic b_in_ready, b_out_valid, b_busy, b_mis, b_err;
    logic [W-1:0] b_dp_a, b_dp_b, b_dp_c, b_out_c, b_or;
    logic [TXN_W-1:0] b_txn;

    // instance C: SETTLE_CYCLES=1, clk_f (too short for the datapath)
    logic c_rst = 1'b1, c_in_valid = 1'b0, c_out_ready = 1'b0;
    logic [W-1:0] c_in_a = '0, c_in_b = '0;
    logic c_in_ready, c_out_valid, c_busy, c_mis, c_err;
    logic [W-1:0] c_dp_a, c_dp_b, c_dp_c, c_out_c, c_or;
    logic [TXN_W-1:0] c_txn;

    // Gate-delay datapath: OR stage 5 units, AND stage 1 unit
    always @(a_dp_a or a_dp_b) a_or   <= #5 (a_dp_a | a_dp_b);
    always @(a_or or a_dp_b)   a_dp_c <= #1 (a_or & a_dp_b);
    always @(b_dp_a or b_dp_b) b_or   <= #5 (b_dp_a | b_dp_b);
    always @(b_or or b_dp_b)   b_dp_c <= #1 (b_or & b_dp_b);
    always @(c_dp_a or c_dp_b) c_or   <= #5 (c_dp_a | c_dp_b);
    always @(c_or or c_dp_b)   c_dp_c <= #1 (c_or & c_dp_b);

    settle_sampler_ctrl #(.WIDTH(W), .SETTLE_CYCLES(SET_A), .CNT_W(4), .TXN_W(TXN_W)) u_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_a(a_in_a), .in_b(a_in_b), .dp_a(a_dp_a), .dp_b(a_dp_b), .dp_c(a_dp_c),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_c(a_out_c),
        .busy(a_busy), .txn_cnt(a_txn), .mismatch(a_mis), .err_sticky(a_err));

    settle_sampler_ctrl #(.WIDTH(W), .SETTLE_CYCLES(0), .CNT_W(4), .TXN_W(TXN_W)) u_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .dp_a(b_dp_a), .dp_b(b_dp_b), .dp_c(b_dp_c),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_c(b_out_c),
        .busy(b_busy), .txn_cnt(b_txn), .mismatch(b_mis), .err_sticky(b_err));

    settle_sampler_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1), .CNT_W(4), .TXN_W(TXN_W)) u_c (
        .clk(clk_f), .rst(c_rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_a(c_in_a), .in_b(c_in_b), .dp_a(c_dp_a), .dp_b(c_dp_b), .dp_c(c_dp_c),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_c(c_out_c),
        .busy(c_busy), .txn_cnt(c_txn), .mismatch(c_mis), .err_sticky(c_err));

    // Reference: settled value of the OR->AND datapath
    function automatic logic [W-1:0] gate_model(input logic [W-1:0] x, input logic [W-1:0] y);
        return (x | y) & y;
    endfunction

    int exp_txn_a = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_f();
        @(posedge clk_f);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b want 0", a_in_ready); end
        checks++;
        if ({a_out_valid, a_busy, a_mis, a_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got ov/busy/mis/err=%b want 0000", {a_out_valid, a_busy, a_mis, a_err});
        end
        checks++;
        if ({a_dp_a, a_dp_b, a_out_c} !== '0 || a_txn !== '0) begin
            errors++; $display("FAIL reset_regs: got dp_a=%b dp_b=%b out_c=%b txn=%0d want zeros", a_dp_a, a_dp_b, a_out_c, a_txn);
        end
        a_rst = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", a_in_ready); end
    endtask

    task automatic test_reset_mid_wait();
        int bad;
        a_in_a = 1'b1; a_in_b = 1'b1; a_in_valid = 1'b1;
        tick();                                  // accept edge E0
        a_in_valid = 1'b0;
        checks++;
        if (a_busy !== 1'b1 || a_dp_a !== 1'b1 || a_dp_b !== 1'b1) begin
            errors++; $display("FAIL midwait_accept: got busy=%b dp_a=%b dp_b=%b want 1 1 1", a_busy, a_dp_a, a_dp_b);
        end
        tick(); tick();                          // E1, E2
        a_rst = 1'b1;
        tick();                                  // E3 with reset
        checks++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_dp_a !== 1'b0 || a_dp_b !== 1'b0 || a_txn !== '0) begin
            errors++; $display("FAIL midwait_reset: got ov=%b busy=%b dp_a=%b dp_b=%b txn=%0d want 0 0 0 0 0",
                               a_out_valid, a_busy, a_dp_a, a_dp_b, a_txn);
        end
        a_rst = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin errors++; $display("FAIL midwait_ready_after: got %b want 1", a_in_ready); end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (a_out_valid !== 1'b0 || a_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL midwait_no_output: got %0d bad cycles want 0", bad); end
        exp_txn_a = 0;
    endtask

    task automatic txn_a(input logic [W-1:0] ta, input logic [W-1:0] tb_);
        int bad;
        logic [W-1:0] exp_c;
        exp_c = gate_model(ta, tb_);
        a_in_a = ta; a_in_b = tb_; a_in_valid = 1'b1;
        checks++;
        if (a_in_ready !== 1'b1) begin errors++; $display("FAIL nom_ready_pre: got %b want 1", a_in_ready); end
        tick();                                  // E0
        a_in_valid = 1'b0;
        a_in_a = W'($urandom); a_in_b = W'($urandom);
        bad = 0;
        for (int k = 1; k < SET_A; k++) begin
            tick();
            if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_dp_a !== ta || a_dp_b !== tb_) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL nom_wait_window: got %0d bad cycles want 0", bad); end
        tick();                                  // capture edge
        checks++;
        if (a_out_valid !== 1'b1) begin errors++; $display("FAIL nom_latency: got out_valid=%b want 1", a_out_valid); end
        checks++;
        if (a_out_c !== exp_c) begin errors++; $display("FAIL nom_out_c: a=%b b=%b got %b want %b", ta, tb_, a_out_c, exp_c); end
        checks++;
        if (a_mis !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL nom_mismatch: got mis=%b err=%b want 0 0", a_mis, a_err); end
        a_out_ready = 1'b1;
        checks++;
        if (a_in_ready !== 1'b0) begin errors++; $display("FAIL nom_ready_done: got %b want 0", a_in_ready); end
        tick();                                  // handshake edge
        a_out_ready = 1'b0;
        exp_txn_a++;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_txn !== TXN_W'(exp_txn_a)) begin
            errors++; $display("FAIL nom_handshake: got ov=%b rdy=%b txn=%0d want 0 1 %0d", a_out_valid, a_in_ready, a_txn, exp_txn_a);
        end
        checks++;
        if (a_dp_a !== ta || a_dp_b !== tb_) begin
            errors++; $display("FAIL nom_dp_hold: got dp_a=%b dp_b=%b want %b %b", a_dp_a, a_dp_b, ta, tb_);
        end
    endtask

    task automatic test_nominal();
        txn_a(1'b1, 1'b0);
        txn_a(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) txn_a(W'($urandom), W'($urandom));
    endtask

    task automatic test_backpressure();
        int bad, waited;
        logic [W-1:0] ta, tb_, exp_c;
        ta = W'($urandom); tb_ = W'($urandom);
        exp_c = gate_model(ta, tb_);
        a_in_a = ta; a_in_b = tb_; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        waited = 0;
        while (a_out_valid !== 1'b1 && waited < 20) begin tick(); waited++; end
        checks++;
        if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: got out_valid=%b want 1", a_out_valid); end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            a_in_valid = 1'($urandom); a_in_a = W'($urandom); a_in_b = W'($urandom);
            tick();
            if (a_out_valid !== 1'b1 || a_out_c !== exp_c || a_in_ready !== 1'b0 || a_dp_a !== ta || a_dp_b !== tb_) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d bad cycles want 0", bad); end
        a_in_valid = 1'b1;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        exp_txn_a++;
        checks++;
        if (a_txn !== TXN_W'(exp_txn_a) || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
            errors++; $display("FAIL bp_release: got txn=%0d rdy=%b busy=%b want %0d 1 0", a_txn, a_in_ready, a_busy, exp_txn_a);
        end
        a_in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q[$];
        logic [W-1:0] exp_c;
        int exp_txn, bad_ctl, bad_data, bad_txn, phase;
        b_rst = 1'b1;
        repeat (3) tick();
        b_rst = 1'b0;
        b_out_ready = 1'b1;
        b_in_valid = 1'b1;
        b_in_a = W'($urandom); b_in_b = W'($urandom);
        #1;
        exp_txn = 0; bad_ctl = 0; bad_data = 0; bad_txn = 0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            phase = cyc % 3;
            if (b_in_ready !== (phase == 0) || b_out_valid !== (phase == 2) || b_busy !== (phase != 0)) bad_ctl++;
            if (phase == 0) q.push_back(gate_model(b_in_a, b_in_b));
            if (phase == 2) begin
                exp_c = (q.size() > 0) ? q.pop_front() : 'x;
                if (b_out_c !== exp_c) bad_data++;
            end
            tick();
            if (phase == 1) begin b_in_a = W'($urandom); b_in_b = W'($urandom); end
            if (phase == 2) begin
                exp_txn++;
                if (b_txn !== TXN_W'(exp_txn)) bad_txn++;
                if (exp_txn == 256) begin
                    checks++;
                    if (b_txn !== '0) begin errors++; $display("FAIL b2b_wrap: got %0d want 0", b_txn); end
                end
            end
        end
        b_in_valid = 1'b0;
        checks++;
        if (bad_ctl != 0) begin errors++; $display("FAIL b2b_timing: got %0d bad cycles want 0", bad_ctl); end
        checks++;
        if (bad_data != 0) begin errors++; $display("FAIL b2b_data: got %0d bad results want 0", bad_data); end
        checks++;
        if (bad_txn != 0) begin errors++; $display("FAIL b2b_txn_track: got %0d bad counts want 0", bad_txn); end
        checks++;
        if (b_txn !== TXN_W'(300 % 256)) begin errors++; $display("FAIL b2b_final_txn: got %0d want %0d", b_txn, 300 % 256); end
        checks++;
        if (b_mis !== 1'b0 || b_err !== 1'b0) begin errors++; $display("FAIL b2b_err: got mis=%b err=%b want 0 0", b_mis, b_err); end
    endtask

    task automatic test_too_short();
        logic [W-1:0] settled, ideal;
        int bad;
        c_rst = 1'b1;
        repeat (10) tick_f();
        c_rst = 1'b0;
        settled = gate_model('0, '0);            // datapath output after reset
        c_in_a = 1'b0; c_in_b = 1'b1; c_in_valid = 1'b1;
        ideal = gate_model(c_in_a, c_in_b);
        tick_f();                                // accept
        c_in_valid = 1'b0;
        tick_f();                                // capture, datapath still settling
        checks++;
        if (c_out_valid !== 1'b1 || c_out_c !== settled) begin
            errors++; $display("FAIL short_stale: got ov=%b out_c=%b want 1 %b", c_out_valid, c_out_c, settled);
        end
        checks++;
        if (c_mis !== (CHK_EN && (settled != ideal)) || c_err !== (CHK_EN && (settled != ideal))) begin
            errors++; $display("FAIL short_flags: got mis=%b err=%b want %b", c_mis, c_err, CHK_EN && (settled != ideal));
        end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick_f();
            if (c_out_c !== settled || c_out_valid !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL short_hold: got %0d bad cycles want 0", bad); end
        c_out_ready = 1'b1;
        tick_f();
        c_out_ready = 1'b0;
        checks++;
        if (c_mis !== 1'b0 || c_err !== CHK_EN) begin
            errors++; $display("FAIL short_clear: got mis=%b err=%b want 0 %b", c_mis, c_err, CHK_EN);
        end
        // same operands again: datapath already settled, so capture is correct
        c_in_valid = 1'b1;
        tick_f();
        c_in_valid = 1'b0;
        tick_f();
        checks++;
        if (c_out_valid !== 1'b1 || c_out_c !== ideal || c_mis !== 1'b0 || c_err !== CHK_EN) begin
            errors++; $display("FAIL short_second: got ov=%b out_c=%b mis=%b err=%b want 1 %b 0 %b",
                               c_out_valid, c_out_c, c_mis, c_err, ideal, CHK_EN);
        end
        c_out_ready = 1'b1;
        tick_f();
        c_out_ready = 1'b0;
        checks++;
        if (c_txn !== TXN_W'(2) || c_in_ready !== 1'b1) begin
            errors++; $display("FAIL short_txn: got txn=%0d rdy=%b want 2 1", c_txn, c_in_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_nominal();
        test_backpressure();
        test_back_to_back();
        test_too_short();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
